// File: rtl/program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and word geometry.
package program_loader_pkg;
  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } loader_state_t;
endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake into the loader; a transfer is byte_valid & byte_ready.
interface program_loader_if;
  import program_loader_pkg::*;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);
endinterface

// File: rtl/program_loader_packer.sv
// byte_to_word_packer: gathers WORD_BYTES bytes, LSB first, into one word.
// done is high in the cycle the final byte is presented, with word already
// complete, so the owner can register the result on that same edge.
module byte_to_word_packer
  import program_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    done
);
  logic [IDX_W-1:0]           idx;
  logic [WORD_BYTES-2:0][7:0] lane;

  assign done = in_valid && (idx == IDX_W'(WORD_BYTES - 1));
  assign word = {in_byte, lane};

  // Byte index and lower byte lanes; index restarts whenever the owner changes phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      lane <= '0;
    end else begin
      if (clr)           idx <= '0;
      else if (in_valid) idx <= idx + IDX_W'(1);
      for (int g = 0; g < WORD_BYTES - 1; g++)
        if (in_valid && idx == IDX_W'(g)) lane[g] <= in_byte;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: receives a word-count header plus little-endian words over a
// byte stream and writes them to instruction memory from BASE_ADDR upward,
// keeping the core in reset until the image is complete.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst,
  program_loader_if.slave   bs,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       words_done,
  output logic              core_run,
  output logic              load_err
);
  loader_state_t state;
  logic [31:0]   count;
  logic          take;
  logic          pk_valid;
  logic          pk_done;
  logic [31:0]   pk_word;
  logic          last_word;
  logic          pk_clr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  assign take      = bs.byte_valid && bs.byte_ready;
  assign pk_valid  = take && (state == S_HDR || state == S_DATA);
  assign last_word = (words_done + 32'd1) == count;
  // Phase change: header complete, or last data word complete.
  assign pk_clr    = pk_done && (state == S_HDR || last_word);

  byte_to_word_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (pk_clr),
    .in_valid (pk_valid),
    .in_byte  (bs.byte_data),
    .word     (pk_word),
    .done     (pk_done)
  );

  // Loader FSM with registered write strobe, status and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_HDR;
      count         <= '0;
      words_done    <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= BASE_ADDR;
      wr_data       <= '0;
      core_run      <= 1'b0;
      load_err      <= 1'b0;
      bs.byte_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_HDR: begin
          if (pk_done) begin
            count <= pk_word;
            if (pk_word == '0) begin
              // Empty image: release the core right away.
              state         <= S_DONE;
              core_run      <= 1'b1;
              bs.byte_ready <= 1'b0;
            end else if (pk_word > 32'(MAX_WORDS)) begin
              state         <= S_ERR;
              load_err      <= 1'b1;
              bs.byte_ready <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
`ifdef LOADER_CHECKSUM_EN
          if (pk_valid) csum <= csum ^ bs.byte_data;
`endif
          if (pk_done) begin
            wr_en      <= 1'b1;
            wr_data    <= pk_word;
            wr_addr    <= BASE_ADDR + (words_done << 2);
            words_done <= words_done + 32'd1;
            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CHK;
`else
              // core_run follows one cycle later, from S_DONE.
              state         <= S_DONE;
              bs.byte_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (take) begin
            bs.byte_ready <= 1'b0;
            if (bs.byte_data == csum) begin
              state <= S_DONE;
            end else begin
              state    <= S_ERR;
              load_err <= 1'b1;
            end
          end
        end
`endif
        S_DONE: begin
          core_run      <= 1'b1;
          bs.byte_ready <= 1'b0;
        end
        S_ERR: begin
          load_err      <= 1'b1;
          core_run      <= 1'b0;
          bs.byte_ready <= 1'b0;
        end
        default: begin
          state <= S_ERR;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a stream-level model predicts the
// write sequence and final status; a negedge monitor scores each write strobe.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 32768;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en, core_run, load_err;
  logic [31:0] wr_addr, wr_data, words_done;

  program_loader_if bs();

  program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bs         (bs),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .words_done (words_done),
    .core_run   (core_run),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  wr_t e;
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  run_after_last = 1'b0;
  bit  chk_run_next   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (chk_run_next) begin
      chk_run_next = 1'b0;
      check("core_run_after_last_strobe", core_run, 32'd1);
    end
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write %h@%h, expected none", wr_data, wr_addr);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        if (exp_q.size() == 0 && run_after_last) begin
          check("core_run_at_last_strobe", core_run, 32'd0);
          chk_run_next = 1'b1;
        end
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    bs.byte_valid = 1'b0;
    bs.byte_data  = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(negedge clk);
    check("rst_byte_ready", bs.byte_ready, 32'd1);
    check("rst_wr_en",      wr_en,         32'd0);
    check("rst_wr_addr",    wr_addr,       BASE);
    check("rst_wr_data",    wr_data,       32'd0);
    check("rst_words_done", words_done,    32'd0);
    check("rst_core_run",   core_run,      32'd0);
    check("rst_load_err",   load_err,      32'd0);
    @(posedge clk); #1;
  endtask

  // Drive one byte after 'gap' idle cycles; waits for byte_ready with a bound.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    bs.byte_valid = 1'b1;
    bs.byte_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (bs.byte_ready) break;
      n++;
      if (n > 20) begin
        n_checks++;
        n_fail++;
        $display("FAIL byte_accept_timeout: byte_ready stayed 0, expected 1");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bs.byte_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input int maxgap);
    foreach (s[i]) send_byte(s[i], (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0)));
  endtask

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] data_xor(input bq_t s);
    logic [7:0] x = '0;
    for (int i = 4; i < s.size(); i++) x ^= s[i];
    return x;
  endfunction
`endif

  // Reference model: interprets the stream by the loader's rules and queues expected writes.
  task automatic model(input bq_t s, output logic [31:0] ew, output bit er, output bit ee);
    logic [31:0] cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  x;
    x = '0;
`endif
    cnt = {s[3], s[2], s[1], s[0]};
    ew = '0; er = 1'b0; ee = 1'b0;
    if (cnt == 0) er = 1'b1;
    else if (cnt > MAXW) ee = 1'b1;
    else begin
      for (int k = 0; k < int'(cnt); k++) begin
        exp_q.push_back('{addr: BASE + 32'(4 * k),
                          data: {s[4*k+7], s[4*k+6], s[4*k+5], s[4*k+4]}});
`ifdef LOADER_CHECKSUM_EN
        for (int j = 0; j < 4; j++) x ^= s[4*k+4+j];
`endif
      end
      ew = cnt;
`ifdef LOADER_CHECKSUM_EN
      if (s[4 + 4 * int'(cnt)] == x) er = 1'b1; else ee = 1'b1;
`else
      er = 1'b1;
`endif
    end
  endtask

  task automatic make_stream(input logic [31:0] cnt, input bit bad, output bq_t s);
    logic [31:0] w;
    s = {};
    for (int i = 0; i < 4; i++) s.push_back(cnt[8*i +: 8]);
    if (cnt <= 64) begin
      for (int k = 0; k < int'(cnt); k++) begin
        w = $urandom;
        for (int i = 0; i < 4; i++) s.push_back(w[8*i +: 8]);
      end
`ifdef LOADER_CHECKSUM_EN
      if (cnt != 0) s.push_back(data_xor(s) ^ {7'd0, bad});
`else
      if (bad) s.push_back(8'h00);
`endif
    end
  endtask

  task automatic run_case(input string name, input bq_t s, input int maxgap);
    logic [31:0] ew;
    bit er, ee;
    model(s, ew, er, ee);
`ifdef LOADER_CHECKSUM_EN
    run_after_last = 1'b0;
`else
    run_after_last = er && (ew != 0);
`endif
    send_stream(s, maxgap);
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check({name, "_words_done"}, words_done, ew);
    check({name, "_core_run"},   core_run,   32'(er));
    check({name, "_load_err"},   load_err,   32'(ee));
    check({name, "_byte_ready"}, bs.byte_ready, 32'd0);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q = {};
    @(posedge clk); #1;
  endtask

  bq_t t1, s;
  logic [31:0] cnt;

  initial begin
    bs.byte_valid = 1'b0;
    bs.byte_data  = '0;
    t1 = '{8'h02, 8'h00, 8'h00, 8'h00,
           8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    t1.push_back(data_xor(t1));
`endif

    // Two-word image, back-to-back bytes.
    reset_dut();
    run_case("t1", t1, 0);

    // Empty image: core released one cycle after the 4th header byte.
    reset_dut();
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    @(negedge clk);
    check("hdr0_core_run_before", core_run, 32'd0);
    @(posedge clk); #1;
    send_byte(8'h00, 0);
    @(negedge clk);
    check("hdr0_core_run_next", core_run, 32'd1);
    check("hdr0_byte_ready", bs.byte_ready, 32'd0);
    check("hdr0_words_done", words_done, 32'd0);
    @(posedge clk); #1;

    // Oversize header.
    reset_dut();
    s = '{8'h01, 8'h80, 8'h00, 8'h00};
    run_case("oversize", s, 0);

    // Exactly MAX_WORDS is legal: loader must keep accepting data.
    reset_dut();
    s = '{8'h00, 8'h80, 8'h00, 8'h00};
    send_stream(s, 0);
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check("maxw_load_err",   load_err,      32'd0);
    check("maxw_byte_ready", bs.byte_ready, 32'd1);
    check("maxw_core_run",   core_run,      32'd0);
    @(posedge clk); #1;

    // Same image with random idle gaps.
    reset_dut();
    run_case("t1_gaps", t1, 5);

    // Reset after a partial load, then a full resend.
    reset_dut();
    for (int i = 0; i < 6; i++) send_byte(t1[i], 0);
    reset_dut();
    run_case("t1_resend", t1, 0);

    // Random images.
    for (int k = 0; k < 8; k++) begin
      reset_dut();
      cnt = $urandom_range(6, 1);
      make_stream(cnt, 1'b0, s);
      run_case("rand", s, int'($urandom_range(3, 0)));
    end

    // Random oversize header.
    reset_dut();
    cnt = 32'(MAXW) + 32'd1 + $urandom_range(1000, 0);
    make_stream(cnt, 1'b0, s);
    run_case("rand_oversize", s, 2);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: words still written, core held, error raised.
    reset_dut();
    make_stream(32'd3, 1'b1, s);
    run_case("bad_csum", s, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait never resolves.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule
